result_pack_stage: RTL and testbench
====================================

Name: result_pack_stage

Overview:
- Downstream consumer of the edge-case IP's registered result path (16-bit result vector plus status flag), clk domain only.
- Qualifies incoming 16-bit results and packs two consecutive results into one 32-bit word.
- Buffers completed words in a small first-word-fall-through FIFO.
- Presents words on a valid/ready stream, with flush, overflow statistics and drop accounting.

Parameters:
- DEPTH, 4, FIFO depth in 32-bit words; power of 2, minimum 2.
- SKIP_ZERO, 1, when 1 a sample with status_in=0 is discarded; when 0 every qualified sample is packed.
- CNT_W, 16, width of drop_cnt and word_cnt.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  sample strobe; result_in/status_in are valid this cycle
- result_in  in  16  result vector from upstream IP
- status_in  in  1  upstream status flag (nonzero-data indicator)
- flush  in  1  single-cycle request to emit any held partial word
- clr_stats  in  1  synchronous clear of drop_cnt, word_cnt, overflow_sticky
- out_ready  in  1  downstream ready
- out_valid  out  1  head word available
- out_data  out  32  head word; [15:0] older sample, [31:16] newer sample
- out_keep  out  2  half-valid mask of head word (11 full, 01 low half only)
- out_last  out  1  head word was closed by flush
- drop_cnt  out  CNT_W  words lost to FIFO full, saturating
- word_cnt  out  CNT_W  words accepted into FIFO, wrapping
- overflow_sticky  out  1  set on any drop, held until clr_stats

Behaviour:
- Reset (async assert, sync release): FIFO empty, pack FSM in IDLE, and all of the following at 0: out_valid, out_data, out_keep, out_last, drop_cnt, word_cnt, overflow_sticky.
- Accepted sample: in_valid=1 and (SKIP_ZERO=0 or status_in=1). Rejected samples leave all state unchanged.
- Pack FSM has two states.
  - IDLE: an accepted sample is stored in the low-half register; go to HALF.
  - HALF: an accepted sample forms word {sample, low_half} with keep=11; push; go to IDLE.
- Flush rules:
  - flush in HALF with no accepted sample: push {16'h0, low_half}, keep=01, last=1; go to IDLE.
  - flush in HALF with an accepted sample: push the full word with keep=11, last=1; go to IDLE.
  - flush in IDLE with an accepted sample: push {16'h0, sample}, keep=01, last=1; stay IDLE.
  - flush in IDLE with no sample: no effect.
- Non-flush pushes carry last=0.
- At most one push per cycle.
- FIFO is first-word-fall-through.
  - out_valid = not empty; out_data/out_keep/out_last reflect the head entry.
  - Pop occurs when out_valid & out_ready.
- Latency: a push at clock edge N makes the word visible (out_valid=1) after edge N if the FIFO was empty; one-cycle minimum.
- Full handling:
  - A push when full with no pop in the same cycle drops the word: FIFO unchanged, drop_cnt += 1 (saturates at all-ones), overflow_sticky=1, word_cnt unchanged.
  - Push and pop in the same cycle while full: both succeed; count stays DEPTH.
  - Push into empty FIFO with out_ready=1: word appears next cycle; no bypass.
- word_cnt increments once per successful push and wraps modulo 2^CNT_W.
- FIFO pointers are log2(DEPTH)+1 bits wide and wrap naturally. Full/empty are derived from MSB comparison.
- clr_stats clears the counters and the sticky bit on the next edge.
  - If clr_stats coincides with a drop or push, clear wins: the counter reads 0 and the sticky bit reads 0.
  - clr_stats does not affect FIFO contents or FSM state.
- out_valid must stay asserted with stable out_data/out_keep/out_last until popped.
- Reset mid-operation discards the held partial half and all buffered words; no words are emitted after reset release until new samples arrive.

Test Plan:
- Packing order: reset; accepted samples 16'h1111, 16'h2222 with out_ready=1 → one word 32'h2222_1111, keep=11, last=0; word_cnt=1.
- Zero skip: SKIP_ZERO=1; samples (16'h00AA, status 0), (16'h0BBB, status 1), (16'h0CCC, status 1) → single word 32'h0CCC_0BBB; the status-0 sample never appears.
- Flush paths:
  - One sample 16'h5A5A, then flush → word 32'h0000_5A5A, keep=01, last=1.
  - flush alone in IDLE → no out_valid.
  - Same-cycle second sample plus flush → full word, last=1.
- Overflow: DEPTH=4, out_ready=0; push 6 full words → 4 buffered, drop_cnt=2, overflow_sticky=1, word_cnt=4. Drain → the first 4 words appear in order.
- Full push+pop: FIFO full, out_ready=1 in the same cycle a word completes → no drop, count remains 4, drop_cnt unchanged.
- Reset and clr_stats:
  - Hold a partial half plus 2 buffered words, assert rst_n low mid-stream → out_valid=0 and all counters 0 immediately (async).
  - After release, 1 sample + flush → only that keep=01 word.
  - clr_stats coinciding with a drop → drop_cnt=0, overflow_sticky=0.

Source files
------------

// File: rtl/result_pack_stage.sv
// Packs pairs of qualified 16-bit results into 32-bit words and buffers them in a
// first-word-fall-through FIFO feeding a valid/ready stream, with drop accounting.
module result_pack_stage #(
    parameter int unsigned DEPTH     = 4,
    parameter bit          SKIP_ZERO = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [15:0]      result_in,
    input  logic             status_in,
    input  logic             flush,
    input  logic             clr_stats,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [31:0]      out_data,
    output logic [1:0]       out_keep,
    output logic             out_last,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] word_cnt,
    output logic             overflow_sticky
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrOne = 1;
    localparam logic [CNT_W-1:0] CntOne = 1;

    typedef enum logic [0:0] {StIdle, StHalf} state_e;

    state_e state_q, state_d;
    logic [15:0] low_q;

    logic        accepted;
    logic        push;
    logic [31:0] push_data;
    logic [1:0]  push_keep;
    logic        push_last;
    logic        load_low;

    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic [31:0] mem_data [DEPTH];
    logic [1:0]  mem_keep [DEPTH];
    logic        mem_last [DEPTH];
    logic        empty, full, pop, push_ok, drop;

    logic [CNT_W-1:0] drop_cnt_q, word_cnt_q;
    logic             sticky_q;

    assign accepted = in_valid && (!SKIP_ZERO || status_in);

    // Pack FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Pack FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accepted && !flush) state_d = StHalf;
            StHalf: if (accepted || flush) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Pack FSM: push word formation
    always_comb begin
        push      = 1'b0;
        push_data = 32'h0;
        push_keep = 2'b00;
        push_last = 1'b0;
        load_low  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accepted && flush) begin
                    push      = 1'b1;
                    push_data = {16'h0, result_in};
                    push_keep = 2'b01;
                    push_last = 1'b1;
                end else if (accepted) begin
                    load_low = 1'b1;
                end
            end
            StHalf: begin
                if (accepted) begin
                    push      = 1'b1;
                    push_data = {result_in, low_q};
                    push_keep = 2'b11;
                    push_last = flush;
                end else if (flush) begin
                    push      = 1'b1;
                    push_data = {16'h0, low_q};
                    push_keep = 2'b01;
                    push_last = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            low_q <= 16'h0;
        end else if (load_low) begin
            low_q <= result_in;
        end
    end

    // Extra pointer MSB distinguishes full from empty when the indices match
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop     = !empty && out_ready;
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop)     rd_ptr_q <= rd_ptr_q + PtrOne;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_data[wr_ptr_q[AW-1:0]] <= push_data;
            mem_keep[wr_ptr_q[AW-1:0]] <= push_keep;
            mem_last[wr_ptr_q[AW-1:0]] <= push_last;
        end
    end

    // Head fields are gated so stale storage never shows while the FIFO is empty
    assign out_valid = !empty;
    assign out_data  = empty ? 32'h0 : mem_data[rd_ptr_q[AW-1:0]];
    assign out_keep  = empty ? 2'b00 : mem_keep[rd_ptr_q[AW-1:0]];
    assign out_last  = empty ? 1'b0  : mem_last[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
            word_cnt_q <= '0;
            sticky_q   <= 1'b0;
        end else if (clr_stats) begin
            drop_cnt_q <= '0;
            word_cnt_q <= '0;
            sticky_q   <= 1'b0;
        end else begin
            if (push_ok) word_cnt_q <= word_cnt_q + CntOne;
            if (drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + CntOne;
            if (drop) sticky_q <= 1'b1;
        end
    end

    assign drop_cnt        = drop_cnt_q;
    assign word_cnt        = word_cnt_q;
    assign overflow_sticky = sticky_q;

endmodule

// File: tb/tb_result_pack_stage.sv
// Directed bench for result_pack_stage (DEPTH=4, SKIP_ZERO=1, CNT_W=16).
module tb_result_pack_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] result_in;
    logic        status_in;
    logic        flush;
    logic        clr_stats;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [1:0]  out_keep;
    logic        out_last;
    logic [15:0] drop_cnt;
    logic [15:0] word_cnt;
    logic        overflow_sticky;

    int n_vec = 0;
    int n_err = 0;

    result_pack_stage #(
        .DEPTH(4),
        .SKIP_ZERO(1'b1),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .result_in(result_in),
        .status_in(status_in),
        .flush(flush),
        .clr_stats(clr_stats),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_keep(out_keep),
        .out_last(out_last),
        .drop_cnt(drop_cnt),
        .word_cnt(word_cnt),
        .overflow_sticky(overflow_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] r, input logic s, input logic f);
        in_valid  = 1'b1;
        result_in = r;
        status_in = s;
        flush     = f;
        step();
        in_valid  = 1'b0;
        status_in = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic push_word(input logic [15:0] lo, input logic [15:0] hi);
        send(lo, 1'b1, 1'b0);
        send(hi, 1'b1, 1'b0);
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic [31:0] d, input logic [1:0] k,
                              input logic l);
        check({tag, "_valid"}, {31'h0, out_valid}, 32'h1);
        check({tag, "_data"}, out_data, d);
        check({tag, "_keep"}, {30'h0, out_keep}, {30'h0, k});
        check({tag, "_last"}, {31'h0, out_last}, {31'h0, l});
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; result_in = 16'h0; status_in = 1'b0;
        flush = 1'b0; clr_stats = 1'b0; out_ready = 1'b0;
        #3;
        check("rst_valid", {31'h0, out_valid}, 32'h0);
        check("rst_data", out_data, 32'h0);
        check("rst_keep", {30'h0, out_keep}, 32'h0);
        check("rst_last", {31'h0, out_last}, 32'h0);
        check("rst_drop", {16'h0, drop_cnt}, 32'h0);
        check("rst_words", {16'h0, word_cnt}, 32'h0);
        check("rst_sticky", {31'h0, overflow_sticky}, 32'h0);
        step();
        rst_n = 1'b1;
        step();

        // Packing order
        send(16'h1111, 1'b1, 1'b0);
        check("pack_half_valid", {31'h0, out_valid}, 32'h0);
        send(16'h2222, 1'b1, 1'b0);
        check_head("pack", 32'h2222_1111, 2'b11, 1'b0);
        check("pack_words", {16'h0, word_cnt}, 32'h1);
        pop_one();
        check("pack_drained", {31'h0, out_valid}, 32'h0);

        // Zero skip
        send(16'h00AA, 1'b0, 1'b0);
        send(16'h0BBB, 1'b1, 1'b0);
        check("skip_half_valid", {31'h0, out_valid}, 32'h0);
        send(16'h0CCC, 1'b1, 1'b0);
        check_head("skip", 32'h0CCC_0BBB, 2'b11, 1'b0);
        pop_one();

        // Flush paths
        send(16'h5A5A, 1'b1, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_head("flush_half", 32'h0000_5A5A, 2'b01, 1'b1);
        pop_one();
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        check("flush_idle_valid", {31'h0, out_valid}, 32'h0);
        send(16'h1234, 1'b1, 1'b0);
        send(16'h5678, 1'b1, 1'b1);
        check_head("flush_full", 32'h5678_1234, 2'b11, 1'b1);
        pop_one();
        send(16'h9999, 1'b1, 1'b1);
        check_head("flush_idle_sample", 32'h0000_9999, 2'b01, 1'b1);
        pop_one();
        check("flush_words", {16'h0, word_cnt}, 32'h5);

        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        check("clr_words", {16'h0, word_cnt}, 32'h0);

        // Overflow: six words into a four-deep FIFO
        for (int k = 0; k < 6; k++) push_word(16'hA000 + 16'(k), 16'hB000 + 16'(k));
        check("ovf_drop", {16'h0, drop_cnt}, 32'h2);
        check("ovf_sticky", {31'h0, overflow_sticky}, 32'h1);
        check("ovf_words", {16'h0, word_cnt}, 32'h4);
        for (int k = 0; k < 4; k++) begin
            check_head("ovf_drain", {16'hB000 + 16'(k), 16'hA000 + 16'(k)}, 2'b11, 1'b0);
            pop_one();
        end
        check("ovf_empty", {31'h0, out_valid}, 32'h0);

        // Full with simultaneous push and pop
        for (int k = 0; k < 4; k++) push_word(16'hC000 + 16'(k), 16'hD000 + 16'(k));
        send(16'hC004, 1'b1, 1'b0);
        out_ready = 1'b1;
        send(16'hD004, 1'b1, 1'b0);
        out_ready = 1'b0;
        check("pp_drop", {16'h0, drop_cnt}, 32'h2);
        check("pp_words", {16'h0, word_cnt}, 32'h9);
        for (int k = 1; k < 5; k++) begin
            check_head("pp_drain", {16'hD000 + 16'(k), 16'hC000 + 16'(k)}, 2'b11, 1'b0);
            pop_one();
        end
        check("pp_empty", {31'h0, out_valid}, 32'h0);

        // clr_stats coinciding with a drop
        for (int k = 0; k < 4; k++) push_word(16'hE000 + 16'(k), 16'hF000 + 16'(k));
        check("clrdrop_pre_words", {16'h0, word_cnt}, 32'hD);
        send(16'hE004, 1'b1, 1'b0);
        clr_stats = 1'b1;
        send(16'hF004, 1'b1, 1'b0);
        clr_stats = 1'b0;
        check("clrdrop_drop", {16'h0, drop_cnt}, 32'h0);
        check("clrdrop_sticky", {31'h0, overflow_sticky}, 32'h0);
        check("clrdrop_words", {16'h0, word_cnt}, 32'h0);
        check_head("clrdrop_head", 32'hF000_E000, 2'b11, 1'b0);

        // Asynchronous reset with a partial half and two buffered words
        pop_one();
        pop_one();
        push_word(16'h1010, 16'h2020);
        pop_one();
        send(16'h3030, 1'b1, 1'b0);
        check("mid_words", {16'h0, word_cnt}, 32'h1);
        check("mid_valid", {31'h0, out_valid}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", {31'h0, out_valid}, 32'h0);
        check("async_words", {16'h0, word_cnt}, 32'h0);
        check("async_drop", {16'h0, drop_cnt}, 32'h0);
        check("async_sticky", {31'h0, overflow_sticky}, 32'h0);
        step();
        rst_n = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        check("post_rst_valid", {31'h0, out_valid}, 32'h0);
        send(16'h7777, 1'b1, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_head("post_rst", 32'h0000_7777, 2'b01, 1'b1);
        pop_one();
        check("post_rst_empty", {31'h0, out_valid}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
